// File: rtl/fifo_syn.sv
// Single-clock synchronous FIFO with registered read data and registered full/empty flags.
// Reads and writes are accepted in the same cycle; there is no fall-through from write to q.
module fifo_syn #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_next;
    logic             wa;
    logic             ra;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign wa = wr & (~full | rd);
    assign ra = rd & ~empty;

    always_comb begin
        cnt_next = cnt;
        if (wa && !ra) begin
            cnt_next = cnt + 1'b1;
        end else if (ra && !wa) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Storage is never cleared; empty gates every read after reset.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wp] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            q     <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wa) begin
                wp <= wp + 1'b1;
            end
            if (ra) begin
                q  <= mem[rp];
                rp <= rp + 1'b1;
            end
            cnt   <= cnt_next;
            full  <= (cnt_next == CNT_FULL);
            empty <= (cnt_next == '0);
        end
    end

endmodule

// File: tb/tb_fifo_syn.sv
// Directed testbench for fifo_syn: reset, fill, overflow, drain, simultaneous access,
// empty corner and asynchronous mid-run reset, with hand-computed expected values.
module tb_fifo_syn;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] data;
    logic [7:0] q;
    logic       full;
    logic       empty;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] vals [8] = '{8'hab, 8'h12, 8'h34, 8'h56, 8'h78, 8'hcd, 8'hcc, 8'hdd};

    fifo_syn #(.WIDTH(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (rd),
        .data  (data),
        .q     (q),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; data = '0;
        repeat (4) step();
        tests_run++;
        if (q !== 8'h00) begin tests_failed++; $display("FAIL reset_q got=%h exp=00", q); end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got=%b exp=1", empty); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got=%b exp=0", full); end
        rst = 1'b0;
        step();
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; data = vals[i];
            step();
        end
        wr = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; data = vals[i];
            step();
            tests_run++;
            if (empty !== 1'b0) begin tests_failed++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
            tests_run++;
            if (full !== (i == 7)) begin tests_failed++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 7)); end
        end
        wr = 1'b0;
    endtask

    task automatic test_overflow();
        wr = 1'b1; data = 8'hee;
        step();
        wr = 1'b0;
        tests_run++;
        if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full got=%b exp=1", full); end
        tests_run++;
        if (empty !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty got=%b exp=0", empty); end
        tests_run++;
        if (q !== 8'h00) begin tests_failed++; $display("FAIL ovf_q got=%h exp=00", q); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            step();
            tests_run++;
            if (q !== vals[i]) begin tests_failed++; $display("FAIL drain_q[%0d] got=%h exp=%h", i, q, vals[i]); end
            tests_run++;
            if (empty !== (i == 7)) begin tests_failed++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i == 7)); end
            tests_run++;
            if (full !== 1'b0) begin tests_failed++; $display("FAIL drain_full[%0d] got=%b exp=0", i, full); end
        end
        step();
        rd = 1'b0;
        tests_run++;
        if (q !== 8'hdd) begin tests_failed++; $display("FAIL drain_extra_q got=%h exp=dd", q); end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL drain_extra_empty got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q;
        fill_all();
        tests_run++;
        if (full !== 1'b1) begin tests_failed++; $display("FAIL b2b_prefill_full got=%b exp=1", full); end
        wr = 1'b1; rd = 1'b1; data = 8'hee;
        step();
        wr = 1'b0;
        tests_run++;
        if (q !== 8'hab) begin tests_failed++; $display("FAIL b2b_q got=%h exp=ab", q); end
        tests_run++;
        if (full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full got=%b exp=1", full); end
        for (int i = 1; i < 9; i++) begin
            rd = 1'b1;
            step();
            exp_q = (i < 8) ? vals[i] : 8'hee;
            tests_run++;
            if (q !== exp_q) begin tests_failed++; $display("FAIL b2b_drain_q[%0d] got=%h exp=%h", i, q, exp_q); end
        end
        rd = 1'b0;
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_empty_corner();
        wr = 1'b1; rd = 1'b1; data = 8'h5a;
        step();
        wr = 1'b0;
        tests_run++;
        if (q !== 8'hee) begin tests_failed++; $display("FAIL corner_q_hold got=%h exp=ee", q); end
        tests_run++;
        if (empty !== 1'b0) begin tests_failed++; $display("FAIL corner_empty got=%b exp=0", empty); end
        step();
        rd = 1'b0;
        tests_run++;
        if (q !== 8'h5a) begin tests_failed++; $display("FAIL corner_read_q got=%h exp=5a", q); end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL corner_read_empty got=%b exp=1", empty); end
    endtask

    task automatic test_async_reset();
        wr = 1'b1; data = 8'h11;
        step();
        data = 8'h22;
        step();
        wr = 1'b0; rd = 1'b1;
        step();
        rd = 1'b0;
        tests_run++;
        if (q !== 8'h11) begin tests_failed++; $display("FAIL arst_pre_q got=%h exp=11", q); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (q !== 8'h00) begin tests_failed++; $display("FAIL arst_q got=%h exp=00", q); end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL arst_empty got=%b exp=1", empty); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL arst_full got=%b exp=0", full); end
        #1 rst = 1'b0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        tests_run++;
        if (q !== 8'h00) begin tests_failed++; $display("FAIL arst_read_q got=%h exp=00", q); end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL arst_read_empty got=%b exp=1", empty); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_empty_corner();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_syn.md
# fifo_syn

Single-clock synchronous FIFO that buffers WIDTH-bit words between a producer and a consumer in the same clock domain. It provides write/read strobes, a registered read-data output, and registered full/empty status flags. It is used as a general-purpose rate-smoothing buffer inside a single clock domain.

## Interface

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two ≥ 2. AW = log2(DEPTH) is the pointer width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all state immediately.
- wr  input  1  write request; word on data is stored at the rising edge if the write is accepted.
- rd  input  1  read request; the oldest word is popped to q at the rising edge if the read is accepted.
- data  input  WIDTH  write data.
- q  output  WIDTH  read data; registered.
- full  output  1  high when DEPTH words are stored; registered.
- empty  output  1  high when no words are stored; registered.

## Operation

- Storage: DEPTH x WIDTH register array; write pointer wp and read pointer rp, each AW bits; occupancy counter cnt, AW+1 bits, range 0..DEPTH.
- Pointers wrap naturally modulo DEPTH (DEPTH-1 -> 0). No explicit wrap logic is needed beyond the AW-bit width.
- Write acceptance: wa = wr & (~full | rd). A write while full is accepted only if a read is accepted in the same cycle.
- Read acceptance: ra = rd & ~empty. A read while empty is ignored, even if a write is accepted in the same cycle. There is no fall-through.
- On wa: mem[wp] <= data; wp <= wp+1.
- On ra: q <= mem[rp]; rp <= rp+1.
- Without ra, q holds its previous value.
- cnt update: +1 on wa only; -1 on ra only; unchanged on both or neither.
- Flags are registered from the next-state count: full <= (cnt_next == DEPTH); empty <= (cnt_next == 0).
- Write while full with no read: data is dropped. Memory, pointers, cnt and flags are unchanged. There is no error flag.
- Read while empty: q, pointers, cnt and flags are unchanged.
- Reset, including mid-operation: wp=0, rp=0, cnt=0, q=0, full=0, empty=1. Memory contents need not be cleared and are never visible, because empty=1 blocks reads.

## Timing

- Reset values: q=0, full=0, empty=1. They take effect asynchronously on rst rising, and first clock activity follows the rst fall.
- Write-to-flag latency: empty deasserts in the cycle after the first accepted write's edge. full asserts after the edge that stores the DEPTH-th word.
- Read latency: q presents the popped word right after the edge at which ra=1, so it is usable in the next cycle.
- Minimum write-to-read latency: a word written at edge N can be read at edge N+1 and appears on q after edge N+1.
- Simultaneous rd & wr when 0 < cnt < DEPTH: both are accepted; cnt and flags are unchanged.
- Simultaneous rd & wr when full: both are accepted; full stays 1.
- Simultaneous rd & wr when empty: only the write is accepted; empty deasserts next cycle.
- Throughput: one write and one read per cycle sustained.

## Test plan

- Reset: hold rst=1 for 4 cycles with wr=rd=0 -> q=0, empty=1, full=0. Assert rst asynchronously mid-run -> same values immediately, and a subsequent read is ignored.
- Fill: write ab,12,34,56,78,cd,cc,dd on 8 consecutive edges -> empty falls after the first edge, full rises after the 8th.
- Overflow: with the FIFO full, write ee with rd=0 -> data dropped, full stays 1, and a later drain contains no ee.
- Drain: rd=1 for 8 cycles -> q sequence ab,12,34,56,78,cd,cc,dd, one per edge. empty rises after the 8th read; a 9th read leaves q=dd.
- Simultaneous access: full FIFO with wr=rd=1 and data=ee -> q=ab, full stays 1. Continue with rd=1 only -> ee emerges as the last word after dd, proving wrap-around.
- Empty corner: empty FIFO with wr=rd=1 and data=5a -> q unchanged, empty=0 next cycle. Next rd -> q=5a, empty=1.
